// File: rtl/shift_pattern_engine_if.sv
// Bus bundle for shift_pattern_engine: control inputs from buttons/switches and
// the LED-facing register outputs. The engine attaches through the slave modport;
// whatever drives the controls (board glue or a bench) uses the master modport.
interface shift_pattern_engine_if #(
  parameter int unsigned WIDTH = 5
);

  logic             EN;         // divider enable
  logic [1:0]       MODE;       // 00 shift, 01 rotate, 10 bounce, 11 hold
  logic             DIR;        // 0 toward MSB, 1 toward LSB
  logic             SER_IN;     // serial bit for shift mode
  logic             LOAD;       // parallel-load strobe
  logic [WIDTH-1:0] LOAD_DATA;  // parallel-load value
  logic [WIDTH-1:0] Q;          // register contents
  logic             TICK;       // one-cycle step pulse
  logic             WRAP;       // one-cycle completion / reversal strobe

  modport master (
    output EN,
    output MODE,
    output DIR,
    output SER_IN,
    output LOAD,
    output LOAD_DATA,
    input  Q,
    input  TICK,
    input  WRAP
  );

  modport slave (
    input  EN,
    input  MODE,
    input  DIR,
    input  SER_IN,
    input  LOAD,
    input  LOAD_DATA,
    output Q,
    output TICK,
    output WRAP
  );

endinterface

// File: rtl/shift_pattern_engine.sv
// shift_pattern_engine: tick divider plus a WIDTH-bit pattern register with
// serial-shift, rotate, bounce (ping-pong) and hold step modes.
//
// A step is taken on the clock edge where the registered TICK is high, so Q moves
// one cycle after TICK rises. LOAD and RST are the only other ways Q changes.
//
// Build option: define SHIFT_PATTERN_SYNC_EN to route SER_IN, LOAD and MODE
// through two-flop synchronisers (two extra cycles of latency on those inputs),
// which makes raw button inputs safe. Without it those inputs are used directly
// and must already be synchronous to CLK.
module shift_pattern_engine #(
  parameter int unsigned      WIDTH     = 5,        // 2..32
  parameter int unsigned      DIV       = 2000000,  // cycles per tick, >= 2
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                   CLK,
  input logic                   RST,
  shift_pattern_engine_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DIV);
  localparam int unsigned StepW = $clog2(WIDTH);

  localparam logic [CntW-1:0]  DivLast    = CntW'(DIV - 1);
  // Shift/rotate complete a full cycle after WIDTH steps; bounce reverses after
  // WIDTH-1 steps so the end bit is not shown twice.
  localparam logic [StepW-1:0] LineLast   = StepW'(WIDTH - 1);
  localparam logic [StepW-1:0] BounceLast = StepW'(WIDTH - 2);

  typedef enum logic [1:0] {
    ModeShift  = 2'b00,
    ModeRotate = 2'b01,
    ModeBounce = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  // Conditioned control inputs (synchronised or direct depending on the build)
  logic  ser_in;
  logic  load_in;
  mode_e mode_in;

  // Divider state
  logic [CntW-1:0]  div_cnt_q;
  logic             tick_q;

  // Step engine state
  logic [WIDTH-1:0] q_q;
  logic [StepW-1:0] step_cnt_q;
  logic             bdir_q;
  logic             wrap_q;
  mode_e            mode_q;

  // Step datapath
  logic [WIDTH-1:0] shl_ser;
  logic [WIDTH-1:0] shr_ser;
  logic [WIDTH-1:0] rot_l;
  logic [WIDTH-1:0] rot_r;
  logic [WIDTH-1:0] q_step;
  logic             step_active;
  logic             step_wrap;
  logic             mode_changed;

`ifdef SHIFT_PATTERN_SYNC_EN
  logic [1:0] ser_sync_q;
  logic [1:0] load_sync_q;
  logic [1:0] mode_sync0_q;
  logic [1:0] mode_sync1_q;

  // Two-flop synchronisers; MODE settles to hold so a reset never steps Q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ser_sync_q   <= 2'b00;
      load_sync_q  <= 2'b00;
      mode_sync0_q <= 2'b11;
      mode_sync1_q <= 2'b11;
    end else begin
      ser_sync_q   <= {ser_sync_q[0], bus.SER_IN};
      load_sync_q  <= {load_sync_q[0], bus.LOAD};
      mode_sync0_q <= bus.MODE;
      mode_sync1_q <= mode_sync0_q;
    end
  end

  assign ser_in  = ser_sync_q[1];
  assign load_in = load_sync_q[1];
  assign mode_in = mode_e'(mode_sync1_q);
`else
  assign ser_in  = bus.SER_IN;
  assign load_in = bus.LOAD;
  assign mode_in = mode_e'(bus.MODE);
`endif

  // Candidate next values for every step flavour, selected by mode and direction.
  always_comb begin
    shl_ser = {q_q[WIDTH-2:0], ser_in};
    shr_ser = {ser_in, q_q[WIDTH-1:1]};
    rot_l   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    rot_r   = {q_q[0], q_q[WIDTH-1:1]};

    q_step = q_q;
    case (mode_in)
      ModeShift:  q_step = bus.DIR ? shr_ser : shl_ser;
      ModeRotate: q_step = bus.DIR ? rot_r : rot_l;
      // Bounce follows its own direction flag; DIR only matters at entry or LOAD.
      ModeBounce: q_step = bdir_q ? rot_r : rot_l;
      default:    q_step = q_q;
    endcase

    step_active  = (mode_in != ModeHold);
    mode_changed = (mode_in != mode_q);
    if (mode_in == ModeBounce) begin
      step_wrap = (step_cnt_q == BounceLast);
    end else begin
      step_wrap = (step_cnt_q == LineLast);
    end
  end

  // Free-running tick divider; EN low freezes the count and masks the tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else if (bus.EN) begin
      if (div_cnt_q == DivLast) begin
        div_cnt_q <= '0;
        tick_q    <= 1'b1;
      end else begin
        div_cnt_q <= div_cnt_q + CntW'(1);
        tick_q    <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  // Step engine: LOAD beats a mode change, which beats a pending tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q        <= RESET_VAL;
      step_cnt_q <= '0;
      bdir_q     <= 1'b0;
      wrap_q     <= 1'b0;
      mode_q     <= mode_in;
    end else begin
      mode_q <= mode_in;
      wrap_q <= 1'b0;
      if (load_in) begin
        q_q        <= bus.LOAD_DATA;
        step_cnt_q <= '0;
        bdir_q     <= bus.DIR;
      end else if (mode_changed) begin
        // The tick coinciding with a mode change is deliberately dropped.
        step_cnt_q <= '0;
        bdir_q     <= bus.DIR;
      end else if (tick_q && step_active) begin
        q_q <= q_step;
        if (step_wrap) begin
          step_cnt_q <= '0;
          wrap_q     <= 1'b1;
          if (mode_in == ModeBounce) begin
            bdir_q <= ~bdir_q;
          end
        end else begin
          step_cnt_q <= step_cnt_q + StepW'(1);
        end
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.TICK = tick_q;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_shift_pattern_engine.sv
// Directed bench for shift_pattern_engine (WIDTH=5, DIV=4, RESET_VAL=0).
// A vector table covers load/step behaviour in every mode; hand-written
// sequences cover reset timing, EN freeze, and a mode change on a tick edge.
module tb_shift_pattern_engine;

  localparam int unsigned W = 5;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst;

  shift_pattern_engine_if #(.WIDTH(W)) bus ();

  shift_pattern_engine #(
    .WIDTH    (W),
    .DIV      (D),
    .RESET_VAL(5'b00000)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic [1:0]   mode;
    logic         dir;
    logic         ser;
    logic [W-1:0] data;
    logic [W-1:0] exp_q;
    logic         exp_w;
  } vec_t;

  vec_t         vecs[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] cur;

  function automatic void add(input logic ld, input logic [1:0] m, input logic d,
                              input logic s, input logic [W-1:0] dat,
                              input logic [W-1:0] eq, input logic ew);
    vec_t v;
    v.load = ld; v.mode = m; v.dir = d; v.ser = s; v.data = dat;
    v.exp_q = eq; v.exp_w = ew;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Waits (bounded) for a negedge where TICK is high.
  task automatic wait_tick(output logic ok);
    int n = 0;
    while (bus.TICK !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.TICK === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no TICK expected TICK within 20 cycles");
    end
  endtask

  task automatic do_load(input logic [W-1:0] dat, input logic [1:0] m, input logic d,
                         input string nm);
    bus.LOAD = 1'b1; bus.LOAD_DATA = dat; bus.MODE = m; bus.DIR = d;
    @(negedge clk);
    bus.LOAD = 1'b0;
    check({nm, "_q"}, 32'(bus.Q), 32'(dat));
    check({nm, "_wrap"}, 32'(bus.WRAP), 32'd0);
    cur = dat;
  endtask

  task automatic do_step(input logic [1:0] m, input logic d, input logic s,
                         input logic [W-1:0] eq, input logic ew, input string nm);
    logic ok;
    bus.MODE = m; bus.DIR = d; bus.SER_IN = s;
    wait_tick(ok);
    if (ok) begin
      check({nm, "_pre"}, 32'(bus.Q), 32'(cur));
      @(negedge clk);
      check({nm, "_q"}, 32'(bus.Q), 32'(eq));
      check({nm, "_wrap"}, 32'(bus.WRAP), 32'(ew));
      cur = eq;
    end
  endtask

  // Reset with LOAD asserted alongside, then check the first ticks land every D cycles.
  task automatic reset_seq(input string nm);
    rst = 1'b1; bus.LOAD = 1'b1; bus.LOAD_DATA = 5'b11111; bus.MODE = 2'b11;
    bus.EN = 1'b1; bus.DIR = 1'b0; bus.SER_IN = 1'b0;
    repeat (2) @(negedge clk);
    check({nm, "_q"}, 32'(bus.Q), 32'd0);
    check({nm, "_tick"}, 32'(bus.TICK), 32'd0);
    check({nm, "_wrap"}, 32'(bus.WRAP), 32'd0);
    rst = 1'b0; bus.LOAD = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("%s_tick%0d", nm, k), 32'(bus.TICK), 32'((k % 4) == 0));
    end
    check({nm, "_q_after"}, 32'(bus.Q), 32'd0);
    check({nm, "_wrap_after"}, 32'(bus.WRAP), 32'd0);
    cur = 5'b00000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst = 1'b1;
    bus.EN = 1'b0; bus.MODE = 2'b11; bus.DIR = 1'b0; bus.SER_IN = 1'b0;
    bus.LOAD = 1'b0; bus.LOAD_DATA = '0;

    // Rotate left through a full cycle, then reverse direction mid-mode.
    add(1, 2'b01, 0, 0, 5'b00001, 5'b00001, 0);
    add(0, 2'b01, 0, 0, 5'b0, 5'b00010, 0);
    add(0, 2'b01, 0, 0, 5'b0, 5'b00100, 0);
    add(0, 2'b01, 0, 0, 5'b0, 5'b01000, 0);
    add(0, 2'b01, 0, 0, 5'b0, 5'b10000, 0);
    add(0, 2'b01, 0, 0, 5'b0, 5'b00001, 1);
    add(0, 2'b01, 1, 0, 5'b0, 5'b10000, 0);
    add(0, 2'b01, 1, 0, 5'b0, 5'b01000, 0);
    // Bounce: DIR held at 1 throughout to show it is ignored after entry.
    add(1, 2'b10, 0, 0, 5'b00001, 5'b00001, 0);
    add(0, 2'b10, 1, 0, 5'b0, 5'b00010, 0);
    add(0, 2'b10, 1, 0, 5'b0, 5'b00100, 0);
    add(0, 2'b10, 1, 0, 5'b0, 5'b01000, 0);
    add(0, 2'b10, 1, 0, 5'b0, 5'b10000, 1);
    add(0, 2'b10, 1, 0, 5'b0, 5'b01000, 0);
    add(0, 2'b10, 1, 0, 5'b0, 5'b00100, 0);
    add(0, 2'b10, 1, 0, 5'b0, 5'b00010, 0);
    add(0, 2'b10, 1, 0, 5'b0, 5'b00001, 1);
    add(0, 2'b10, 1, 0, 5'b0, 5'b00010, 0);
    // Serial shift left, then one step right with SER_IN=1.
    add(1, 2'b00, 0, 0, 5'b00000, 5'b00000, 0);
    add(0, 2'b00, 0, 1, 5'b0, 5'b00001, 0);
    add(0, 2'b00, 0, 1, 5'b0, 5'b00011, 0);
    add(0, 2'b00, 0, 1, 5'b0, 5'b00111, 0);
    add(0, 2'b00, 0, 0, 5'b0, 5'b01110, 0);
    add(0, 2'b00, 0, 0, 5'b0, 5'b11100, 1);
    add(0, 2'b00, 1, 1, 5'b0, 5'b11110, 0);
    // Hold: ticks continue, Q and WRAP do not move.
    add(1, 2'b11, 0, 0, 5'b10101, 5'b10101, 0);
    add(0, 2'b11, 0, 0, 5'b0, 5'b10101, 0);
    add(0, 2'b11, 0, 0, 5'b0, 5'b10101, 0);

    reset_seq("rst_init");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].load) begin
        do_load(vecs[i].data, vecs[i].mode, vecs[i].dir, $sformatf("v%0d_load", i));
      end else begin
        do_step(vecs[i].mode, vecs[i].dir, vecs[i].ser, vecs[i].exp_q, vecs[i].exp_w,
                $sformatf("v%0d_step", i));
      end
    end

    // EN low freezes the divider mid-count; LOAD still works; resume finishes the count.
    do_load(5'b10110, 2'b01, 1'b0, "en_load0");
    wait_tick(ok);
    if (ok) begin
      @(negedge clk);
      check("en_step_q", 32'(bus.Q), 32'(5'b01101));
      @(negedge clk);
      bus.EN = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("en_off_tick%0d", k), 32'(bus.TICK), 32'd0);
        check($sformatf("en_off_q%0d", k), 32'(bus.Q), 32'(5'b01101));
      end
      do_load(5'b01010, 2'b01, 1'b0, "en_off_load");
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("en_off2_tick%0d", k), 32'(bus.TICK), 32'd0);
        check($sformatf("en_off2_q%0d", k), 32'(bus.Q), 32'(5'b01010));
      end
      bus.EN = 1'b1;
      @(negedge clk);
      check("en_resume_tick1", 32'(bus.TICK), 32'd0);
      @(negedge clk);
      check("en_resume_tick2", 32'(bus.TICK), 32'd1);
      @(negedge clk);
      check("en_resume_q", 32'(bus.Q), 32'(5'b10100));
    end

    // Switch rotate -> bounce on a tick cycle: the tick is lost and bdir takes DIR=1.
    do_load(5'b01010, 2'b01, 1'b0, "mc_load");
    wait_tick(ok);
    if (ok) begin
      bus.MODE = 2'b10; bus.DIR = 1'b1;
      @(negedge clk);
      check("mc_q_held", 32'(bus.Q), 32'(5'b01010));
      check("mc_wrap", 32'(bus.WRAP), 32'd0);
      cur = 5'b01010;
      do_step(2'b10, 1'b0, 1'b0, 5'b00101, 1'b0, "mc_s1");
      do_step(2'b10, 1'b0, 1'b0, 5'b10010, 1'b0, "mc_s2");
      do_step(2'b10, 1'b0, 1'b0, 5'b01001, 1'b0, "mc_s3");
      do_step(2'b10, 1'b0, 1'b0, 5'b10100, 1'b1, "mc_s4");
      do_step(2'b10, 1'b0, 1'b0, 5'b01001, 1'b0, "mc_s5");
    end

    // Reset in the middle of a count restores everything and restarts tick timing.
    @(negedge clk);
    reset_seq("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_pattern_engine.md
Name: shift_pattern_engine

Overview:
Parametrised successor to the single-purpose LED shift register. It has a built-in tick divider and an N-bit register with four step modes: serial shift, rotate, bounce (ping-pong) and hold. It supports direction select, synchronous parallel load and a wrap/reverse strobe. It sits between board buttons/switches and the LED bank, and is reusable for any WIDTH of LEDs or PMOD outputs.

Parameters:
WIDTH, 5, register width in bits; legal range 2..32.
DIV, 2000000, clock cycles per step tick; legal range >= 2; divider counter width is $clog2(DIV).
RESET_VAL, 0, value loaded into Q on reset; WIDTH bits.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  divider enable; low freezes the divider and suppresses ticks.
MODE  input  2  00 serial shift, 01 rotate, 10 bounce, 11 hold.
DIR  input  1  0 = toward MSB (left), 1 = toward LSB (right).
SER_IN  input  1  serial data bit, used in mode 00 only.
LOAD  input  1  synchronous parallel-load strobe.
LOAD_DATA  input  WIDTH  parallel-load value.
Q  output  WIDTH  register contents, driven to the LEDs.
TICK  output  1  registered one-cycle step pulse.
WRAP  output  1  registered one-cycle strobe at cycle completion or bounce reversal.

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high. RST has priority over every other input.
- Reset values: Q = RESET_VAL; TICK = 0; WRAP = 0; div_cnt = 0; step_cnt = 0; bdir = 0; mode_q = MODE at reset.
- Divider:
  - When EN = 1 and div_cnt == DIV-1: div_cnt <= 0 and TICK <= 1.
  - Otherwise, when EN = 1: div_cnt increments and TICK <= 0.
  - When EN = 0: div_cnt holds and TICK <= 0.
  - TICK period is exactly DIV cycles.
- Step timing: a step is taken on the edge where registered TICK == 1. Q changes one cycle after TICK rises, and that is the only cycle in which Q changes, apart from LOAD and RST.
- Mode 00 (serial shift):
  - DIR=0: Q <= {Q[WIDTH-2:0], SER_IN}.
  - DIR=1: Q <= {SER_IN, Q[WIDTH-1:1]}.
  - SER_IN is sampled on the step edge.
- Mode 01 (rotate):
  - DIR=0: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - DIR=1: Q <= {Q[0], Q[WIDTH-1:1]}.
- Mode 10 (bounce): rotate using the internal bdir instead of DIR. After WIDTH-1 steps, bdir toggles.
- Mode 11 (hold): Q is unchanged. TICK is still generated. step_cnt holds and WRAP stays 0.
- step_cnt and WRAP:
  - In modes 00 and 01, step_cnt counts 0..WIDTH-1. On the step where step_cnt == WIDTH-1, step_cnt <= 0 and WRAP <= 1, coincident with the Q update.
  - In mode 10, step_cnt counts 0..WIDTH-2. On the step where step_cnt == WIDTH-2, step_cnt <= 0, bdir <= ~bdir and WRAP <= 1.
- Mode change: mode_q registers MODE every cycle. When MODE != mode_q, step_cnt <= 0 and bdir <= DIR. No step is taken that cycle, even if TICK == 1; the tick is lost. The divider is unaffected.
- DIR change mid-mode: takes effect on the next step in modes 00 and 01. It is ignored in mode 10 until the next mode entry or LOAD.
- LOAD:
  - Has priority over step and mode change.
  - Q <= LOAD_DATA, step_cnt <= 0, bdir <= DIR, WRAP <= 0.
  - Works with EN = 0.
  - Does not touch the divider.
- Simultaneous RST and LOAD: reset wins.
- Reset mid-step: all state returns to reset values; the first tick arrives DIV cycles after RST is released.

Optional Feature:
Macro SHIFT_PATTERN_SYNC_EN.
- Defined: SER_IN, LOAD and MODE each pass through a two-flop synchroniser (reset to 0; MODE reset to 2'b11) before use. This adds 2 cycles of latency on those inputs and makes the block safe for raw button inputs.
- Undefined: these inputs are used directly. The caller guarantees they are synchronous to CLK.

Test Plan:
1. WIDTH=5, DIV=4, RST held 2 cycles then released, EN=1 -> Q=00000, TICK is high on cycle 4 after release and every 4 cycles thereafter, WRAP=0.
2. LOAD with LOAD_DATA=00001, MODE=01, DIR=0 -> Q steps 00010, 00100, 01000, 10000, 00001. WRAP pulses with the 00001 step. DIR=1 from 00001 gives 10000 first.
3. MODE=10, LOAD 00001, DIR=0 -> Q reaches 10000 after 4 steps with WRAP; then 01000 ... 00001 after 4 more steps with WRAP; then left again.
4. MODE=00, DIR=0, SER_IN=1 for 3 ticks then 0 -> Q = 00001, 00011, 00111, 01110, 11100. WRAP on the 5th step.
5. EN=0 for 10 cycles mid-count -> no TICK, Q frozen. Resume with EN=1 -> next TICK after the remaining div_cnt cycles. LOAD during EN=0 -> Q=LOAD_DATA next cycle.
6. RST and LOAD asserted together -> Q=RESET_VAL. MODE switched 01 to 10 on a TICK cycle -> Q unchanged that cycle, step_cnt=0, bdir=DIR.
